// File: rtl/ssd_scan_mux.sv
// Four-digit seven-segment scan multiplexer.
// - Shows one digit per refresh slot.
// - Double-buffers the segment patterns so that new data is committed only at frame wraps.
// - Supports per-digit enable and blink.
module ssd_scan_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seg0,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    input  logic [7:0] seg3,
    input  logic       load,
    input  logic [3:0] en,
    input  logic [3:0] blink,
    output logic [3:0] an,
    output logic [7:0] seg,
    output logic       pend,
    output logic       frame_tick
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

    logic [CW-1:0] cnt_reg;
    logic [1:0]    idx_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          phase_reg;
    logic          pend_reg;
    logic          frame_tick_reg;
    logic [3:0]    an_reg;
    logic [7:0]    seg_reg;
    logic [7:0]    active_reg  [4];
    logic [7:0]    pending_reg [4];

    logic [7:0]    seg_in [4];
    logic [3:0]    vis_vec;
    logic          slot_tick;
    logic          wrap_tick;
    logic [3:0]    an_next;
    logic [7:0]    seg_next;

    assign slot_tick = (cnt_reg == CNT_MAX);
    assign wrap_tick = slot_tick && (idx_reg == 2'd3);

    // Gather the segment inputs into an indexable array.
    always_comb begin
        seg_in[0] = seg0;
        seg_in[1] = seg1;
        seg_in[2] = seg2;
        seg_in[3] = seg3;
    end

    // Per-digit visibility. The blink phase only blanks digits whose blink bit is set.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_vis
            assign vis_vec[gi] = en[gi] & ~(blink[gi] & phase_reg);
        end
    endgenerate

    // Refresh counter and digit index.
    // The index advances once per slot and wraps 3 -> 0 at the frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
            idx_reg <= 2'd0;
        end else begin
            cnt_reg <= slot_tick ? '0 : cnt_reg + 1'b1;
            if (slot_tick) begin
                idx_reg <= idx_reg + 2'd1;
            end
        end
    end

    // Frame tick pulse, and the blink frame counter / phase toggle, on each wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_tick_reg <= 1'b0;
            blink_cnt_reg  <= '0;
            phase_reg      <= 1'b0;
        end else begin
            frame_tick_reg <= wrap_tick;
            if (wrap_tick) begin
                if (blink_cnt_reg == BLINK_MAX) begin
                    blink_cnt_reg <= '0;
                    phase_reg     <= ~phase_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Double buffer.
    // - A load always lands in pending.
    // - A load on the wrap cycle lands in active as well; otherwise held pending data is committed at the wrap.
    // - Committing only at wraps keeps every frame internally consistent.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                active_reg[i]  <= 8'hFF;
                pending_reg[i] <= 8'hFF;
            end
        end else begin
            if (load && !wrap_tick) begin
                pend_reg <= 1'b1;
            end else if (wrap_tick) begin
                pend_reg <= 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (load) begin
                    pending_reg[i] <= seg_in[i];
                end
                if (wrap_tick && load) begin
                    active_reg[i] <= seg_in[i];
                end else if (wrap_tick && pend_reg) begin
                    active_reg[i] <= pending_reg[i];
                end
            end
        end
    end

    // Next anode/segment values for the current index. en and blink take effect within one cycle.
    always_comb begin
        an_next  = 4'hF;
        seg_next = 8'hFF;
        if (vis_vec[idx_reg]) begin
            an_next  = ~(4'b0001 << idx_reg);
            seg_next = active_reg[idx_reg];
        end
    end

    // Registered display outputs, so there is no combinational input-to-output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_reg  <= 4'hF;
            seg_reg <= 8'hFF;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign pend       = pend_reg;
    assign frame_tick = frame_tick_reg;

endmodule
